mux_3: RTL and testbench



---
 rtl/mux_pkg.sv | 17 +
 rtl/mux_3.sv | 67 ++++++
 tb/tb_mux_3.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the 3-to-1 datapath selector: select-code encoding
// and the default data width used by the RISC-V datapath.
package mux_pkg;

  // Default width of each data input and of the selected output.
  localparam int MUX3_DEFAULT_WIDTH = 32;

  // Select encoding; 2'b11 is the illegal code that yields zero and raises
  // the sticky diagnostic flag.
  typedef enum logic [1:0] {
    SEL_Y0  = 2'b00,
    SEL_Y1  = 2'b01,
    SEL_Y2  = 2'b10,
    SEL_BAD = 2'b11
  } mux3_sel_e;

endpackage

// File: rtl/mux_3.sv
// 3-to-1 data selector for operand/forward and write-back source selection.
// The output is combinational by default; defining MUX3_REG_OUT_EN registers
// it (one cycle of latency, cleared by rst). A sticky flag records whether
// the illegal select code has been seen on any clock edge since reset.
module mux_3
  import mux_pkg::*;
#(
  parameter int Input_size = MUX3_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Input_size-1:0] y0,
  input  logic [Input_size-1:0] y1,
  input  logic [Input_size-1:0] y2,
  input  logic [1:0]            sel,
  output logic [Input_size-1:0] out,
  output logic                  sel_err
);

  mux3_sel_e             w_sel;
  logic [Input_size-1:0] w_selData;
  logic                  r_selErr;

  assign w_sel = mux3_sel_e'(sel);

  // Selection: every legal code picks its input, the illegal code gives zero,
  // and an unknown select propagates as X so it is visible in simulation.
  always_comb begin
    w_selData = '0;
    case (w_sel)
      SEL_Y0:  w_selData = y0;
      SEL_Y1:  w_selData = y1;
      SEL_Y2:  w_selData = y2;
      SEL_BAD: w_selData = '0;
      default: w_selData = 'x;
    endcase
  end

  // Sticky illegal-select flag; reset wins over a simultaneous illegal code.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_selErr <= 1'b0;
    end else if (w_sel == SEL_BAD) begin
      r_selErr <= 1'b1;
    end
  end

  assign sel_err = r_selErr;

`ifdef MUX3_REG_OUT_EN
  logic [Input_size-1:0] r_out;

  // Registered output: one cycle behind the select path, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_selData;
    end
  end

  assign out = r_out;
`else
  assign out = w_selData;
`endif

endmodule

// File: tb/tb_mux_3.sv
// Directed self-checking bench for mux_3 (32-bit and 1-bit instances).
// Covers the combinational build and, when MUX3_REG_OUT_EN is defined, the
// registered-output build.
module tb_mux_3;

  logic        clk;
  logic        rst;
  logic [31:0] y0;
  logic [31:0] y1;
  logic [31:0] y2;
  logic [1:0]  sel;
  logic [31:0] out;
  logic        selErr;

  logic [0:0]  sY0;
  logic [0:0]  sY1;
  logic [0:0]  sY2;
  logic [1:0]  sSel;
  logic [0:0]  sOut;
  logic        sSelErr;

  int checks;
  int failures;

  mux_3 #(.Input_size(32)) dutWide (
    .clk     (clk),
    .rst     (rst),
    .y0      (y0),
    .y1      (y1),
    .y2      (y2),
    .sel     (sel),
    .out     (out),
    .sel_err (selErr)
  );

  mux_3 #(.Input_size(1)) dutNarrow (
    .clk     (clk),
    .rst     (rst),
    .y0      (sY0),
    .y1      (sY1),
    .y2      (sY2),
    .sel     (sSel),
    .out     (sOut),
    .sel_err (sSelErr)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the wide instance and let combinational logic settle.
  task automatic applyStimulus(input logic [1:0] s, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] c);
    sel = s;
    y0  = a;
    y1  = b;
    y2  = c;
    #1;
  endtask

  // Wait until a new output value is observable in the current build.
  task automatic settle();
`ifdef MUX3_REG_OUT_EN
    @(negedge clk);
`else
    #1;
`endif
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    sSel     = 2'b00;
    sY0      = 1'b0;
    sY1      = 1'b1;
    sY2      = 1'b1;
    applyStimulus(2'b00, 32'd10, 32'd20, 32'd30);
    @(negedge clk);
    @(negedge clk);
    checkOutput("resetSelErr", {31'b0, selErr}, 32'd0);
    checkOutput("resetSelErrNarrow", {31'b0, sSelErr}, 32'd0);
    rst = 1'b0;

`ifdef MUX3_REG_OUT_EN
    // Registered build: reset value, one-cycle latency, reset priority.
    checkOutput("regResetOut", out, 32'd0);
    applyStimulus(2'b01, 32'd10, 32'd20, 32'd30);
    checkOutput("regBeforeEdge", out, 32'd0);
    @(negedge clk);
    checkOutput("regAfterEdge", out, 32'd20);
    rst = 1'b1;
    applyStimulus(2'b10, 32'd10, 32'd20, 32'd30);
    @(negedge clk);
    checkOutput("regResetWins", out, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("regAfterReset", out, 32'd30);
`endif

    // Basic selection of each legal code.
    applyStimulus(2'b00, 32'd10, 32'd20, 32'd30);
    settle();
    checkOutput("selY0", out, 32'd10);
    applyStimulus(2'b01, 32'd10, 32'd20, 32'd30);
    settle();
    checkOutput("selY1", out, 32'd20);
    applyStimulus(2'b10, 32'd10, 32'd20, 32'd30);
    settle();
    checkOutput("selY2", out, 32'd30);

    // Non-selected input changes must not disturb out; selected ones must.
    applyStimulus(2'b10, 32'd99, 32'd20, 32'd30);
    settle();
    checkOutput("unselChange", out, 32'd30);
    applyStimulus(2'b10, 32'd99, 32'd20, 32'd77);
    settle();
    checkOutput("selChange", out, 32'd77);
    applyStimulus(2'b01, 32'hDEADBEEF, 32'hA5A5_5A5A, 32'h0);
    settle();
    checkOutput("selY1Pattern", out, 32'hA5A5_5A5A);

    // Sticky flag: one-cycle reset pulse, then one illegal select.
    @(negedge clk);
    applyStimulus(2'b00, 32'd10, 32'd20, 32'd30);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("selErrAfterPulse", {31'b0, selErr}, 32'd0);
    applyStimulus(2'b11, 32'd10, 32'd20, 32'd30);
`ifndef MUX3_REG_OUT_EN
    checkOutput("illegalOutZero", out, 32'd0);
`endif
    checkOutput("selErrBeforeEdge", {31'b0, selErr}, 32'd0);
    @(negedge clk);
    checkOutput("selErrSet", {31'b0, selErr}, 32'd1);
`ifdef MUX3_REG_OUT_EN
    checkOutput("regIllegalOutZero", out, 32'd0);
`endif
    applyStimulus(2'b00, 32'd10, 32'd20, 32'd30);
`ifndef MUX3_REG_OUT_EN
    checkOutput("backToY0", out, 32'd10);
`endif
    @(negedge clk);
    checkOutput("selErrSticky", {31'b0, selErr}, 32'd1);
`ifdef MUX3_REG_OUT_EN
    checkOutput("regBackToY0", out, 32'd10);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("selErrCleared", {31'b0, selErr}, 32'd0);

    // Reset and illegal select on the same edge: reset wins.
    rst = 1'b1;
    applyStimulus(2'b11, 32'd10, 32'd20, 32'd30);
    @(negedge clk);
    checkOutput("resetBeatsIllegal", {31'b0, selErr}, 32'd0);
`ifndef MUX3_REG_OUT_EN
    // Reset has no effect on the combinational output.
    applyStimulus(2'b01, 32'd10, 32'd20, 32'd30);
    checkOutput("resetNoOutEffect", out, 32'd20);
`endif
    rst = 1'b0;
    applyStimulus(2'b00, 32'd10, 32'd20, 32'd30);

    // One-bit instance sweep: y0=0, y1=1, y2=1.
    sSel = 2'b00;
    settle();
    checkOutput("narrowSel00", {31'b0, sOut}, 32'd0);
    sSel = 2'b01;
    settle();
    checkOutput("narrowSel01", {31'b0, sOut}, 32'd1);
    sSel = 2'b10;
    settle();
    checkOutput("narrowSel10", {31'b0, sOut}, 32'd1);
    sSel = 2'b11;
    settle();
    checkOutput("narrowSel11", {31'b0, sOut}, 32'd0);
    @(negedge clk);
    checkOutput("narrowSelErr", {31'b0, sSelErr}, 32'd1);
    checkOutput("wideSelErrUnaffected", {31'b0, selErr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
